// File: rtl/fpu_stim_driver.sv
// fpu_stim_driver: self-test stimulus source and response compactor for the FPU wrapper.
// It issues a fixed, reset-defined pseudo-random request sequence over valid/ready.
// It folds the returned results into a MISR signature. Good and faulty machines
// therefore see the same stimulus and differ only in signature_o.
module fpu_stim_driver #(
    parameter int unsigned      WIDTH           = 32,
    parameter int unsigned      OP_WIDTH        = 4,
    parameter int unsigned      NUM_PATTERNS    = 256,
    parameter int unsigned      MAX_OUTSTANDING = 4,
    parameter logic [WIDTH-1:0] SEED            = WIDTH'(32'h0000_0001),
    parameter logic [WIDTH-1:0] LFSR_POLY       = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0] MISR_POLY       = WIDTH'(32'h04C1_1DB7)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic [WIDTH-1:0]    op_a_o,
    output logic [WIDTH-1:0]    op_b_o,
    output logic [WIDTH-1:0]    op_c_o,
    output logic [OP_WIDTH-1:0] op_o,
    input  logic                resp_valid_i,
    input  logic [WIDTH-1:0]    resp_result_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [15:0]         issued_o,
    output logic [WIDTH-1:0]    signature_o
);

    // Counter wide enough to hold MAX_OUTSTANDING itself
    localparam int unsigned OUT_W = (MAX_OUTSTANDING < 1) ? 1 : $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned HALF  = WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_lfsr;
    logic [WIDTH-1:0]   r_sig;
    logic [15:0]        r_issued;
    logic [OUT_W-1:0]   r_outstanding;

    logic               w_req_valid;
    logic               w_xfer;
    logic               w_resp;
    logic [OUT_W-1:0]   w_out_next;
    logic [15:0]        w_issued_inc;

    // Galois LFSR advance: shift right, fold in the polynomial when bit 0 falls out
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
        lfsr_step = (cur >> 1) ^ (cur[0] ? LFSR_POLY : '0);
    endfunction

    // MISR compaction: shift left with polynomial feedback, then xor in the result
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] data);
        misr_step = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? MISR_POLY : '0) ^ data;
    endfunction

    // Handshake qualifiers and next-value helpers shared by the state update
    always_comb begin
        w_req_valid  = (r_state == S_ISSUE) && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
        w_xfer       = w_req_valid & req_ready_i;
        // A response with nothing in flight is stray (e.g. left over from before reset)
        w_resp       = resp_valid_i & (r_outstanding != '0);
        w_out_next   = r_outstanding;
        case ({w_xfer, w_resp})
            2'b10:   w_out_next = r_outstanding + OUT_W'(1);
            2'b01:   w_out_next = r_outstanding - OUT_W'(1);
            default: w_out_next = r_outstanding;
        endcase
        w_issued_inc = (r_issued == 16'hFFFF) ? r_issued : r_issued + 16'd1;
    end

    // Run-control FSM with the LFSR, MISR and counters it owns
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_lfsr        <= SEED;
            r_sig         <= '0;
            r_issued      <= 16'd0;
            r_outstanding <= '0;
        end else begin
            if (w_xfer) begin
                r_lfsr   <= lfsr_step(r_lfsr);
                r_issued <= w_issued_inc;
            end
            if (w_resp) begin
                r_sig <= misr_step(r_sig, resp_result_i);
            end
            r_outstanding <= w_out_next;

            case (r_state)
                S_IDLE, S_DONE: begin
                    // Every run restarts from the same seed so the stimulus is repeatable
                    if (start_i) begin
                        r_state  <= S_ISSUE;
                        r_lfsr   <= SEED;
                        r_sig    <= '0;
                        r_issued <= 16'd0;
                    end
                end
                S_ISSUE: begin
                    if (w_xfer && (w_issued_inc == 16'(NUM_PATTERNS))) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_out_next == '0) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode directly from registered state so they follow an async reset at once
    always_comb begin
        req_valid_o = w_req_valid;
        op_a_o      = r_lfsr;
        op_b_o      = {r_lfsr[HALF-1:0], r_lfsr[WIDTH-1:HALF]};
        op_c_o      = ~r_lfsr;
        op_o        = r_lfsr[OP_WIDTH-1:0];
        busy_o      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
        done_o      = (r_state == S_DONE);
        issued_o    = r_issued;
        signature_o = r_sig;
    end

endmodule

// File: tb/tb_fpu_stim_driver.sv
// Directed bench for fpu_stim_driver: two instances, one with a wide outstanding
// window (4 patterns, limit 8) and one with a tight window (8 patterns, limit 2).
module tb_fpu_stim_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0, ready_a = 1'b0, resp_v_a = 1'b0;
    logic [31:0] resp_r_a = '0;
    logic        valid_a, busy_a, done_a;
    logic [31:0] opa_a, opb_a, opc_a, sig_a;
    logic [3:0]  opc_code_a;
    logic [15:0] issued_a;

    logic        start_b = 1'b0, ready_b = 1'b0, resp_v_b = 1'b0;
    logic [31:0] resp_r_b = '0;
    logic        valid_b, busy_b, done_b;
    logic [31:0] opa_b, opb_b, opc_b, sig_b;
    logic [3:0]  opc_code_b;
    logic [15:0] issued_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fpu_stim_driver #(.WIDTH(32), .OP_WIDTH(4), .NUM_PATTERNS(4), .MAX_OUTSTANDING(8)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a),
        .req_valid_o(valid_a), .req_ready_i(ready_a),
        .op_a_o(opa_a), .op_b_o(opb_a), .op_c_o(opc_a), .op_o(opc_code_a),
        .resp_valid_i(resp_v_a), .resp_result_i(resp_r_a),
        .busy_o(busy_a), .done_o(done_a), .issued_o(issued_a), .signature_o(sig_a)
    );

    fpu_stim_driver #(.WIDTH(32), .OP_WIDTH(4), .NUM_PATTERNS(8), .MAX_OUTSTANDING(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b),
        .req_valid_o(valid_b), .req_ready_i(ready_b),
        .op_a_o(opa_b), .op_b_o(opb_b), .op_c_o(opc_b), .op_o(opc_code_b),
        .resp_valid_i(resp_v_b), .resp_result_i(resp_r_b),
        .busy_o(busy_b), .done_o(done_b), .issued_o(issued_b), .signature_o(sig_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state
        tick();
        check("rst_valid",  {31'd0, valid_a}, 32'd0);
        check("rst_busy",   {31'd0, busy_a},  32'd0);
        check("rst_done",   {31'd0, done_a},  32'd0);
        check("rst_sig",    sig_a,            32'd0);
        check("rst_issued", {16'd0, issued_a}, 32'd0);
        check("rst_opa",    opa_a,            32'h0000_0001);
        tick();
        rst = 1'b0;

        // ---------------- stray response in IDLE is ignored
        resp_v_a = 1'b1; resp_r_a = 32'h0000_1234;
        tick();
        check("idle_stray_sig", sig_a, 32'd0);
        resp_v_a = 1'b0;

        // ---------------- run 1: four back-to-back transfers, zero results
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("r1_first_valid", {31'd0, valid_a}, 32'd1);
        check("r1_busy",        {31'd0, busy_a},  32'd1);
        check("r1_opa1",        opa_a,            32'h0000_0001);
        check("r1_opb1",        opb_a,            32'h0001_0000);
        check("r1_opc1",        opc_a,            32'hFFFF_FFFE);
        check("r1_op1",         {28'd0, opc_code_a}, 32'd1);
        tick();
        check("r1_issued1", {16'd0, issued_a}, 32'd1);
        check("r1_opa2",    opa_a,             32'h8020_0003);
        tick();
        check("r1_issued2", {16'd0, issued_a}, 32'd2);
        check("r1_opa3",    opa_a,             32'hC030_0002);
        tick();
        check("r1_issued3", {16'd0, issued_a}, 32'd3);
        check("r1_opa4",    opa_a,             32'h6018_0001);
        tick();
        check("r1_issued4",    {16'd0, issued_a}, 32'd4);
        check("r1_drain_vld",  {31'd0, valid_a},  32'd0);
        check("r1_drain_busy", {31'd0, busy_a},   32'd1);
        check("r1_opa5",       opa_a,             32'hB02C_0003);
        resp_v_a = 1'b1; resp_r_a = 32'd0;
        repeat (3) tick();
        check("r1_not_done", {31'd0, done_a}, 32'd0);
        tick();
        resp_v_a = 1'b0;
        check("r1_done",      {31'd0, done_a}, 32'd1);
        check("r1_done_busy", {31'd0, busy_a}, 32'd0);
        check("r1_sig",       sig_a,           32'd0);

        // ---------------- run 2: ready stall, then overlapped responses
        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("r2_done_clr", {31'd0, done_a}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",  {31'd0, valid_a},  32'd1);
            check("stall_opa",    opa_a,             32'h0000_0001);
            check("stall_opb",    opb_a,             32'h0001_0000);
            check("stall_opc",    opc_a,             32'hFFFF_FFFE);
            check("stall_op",     {28'd0, opc_code_a}, 32'd1);
            check("stall_issued", {16'd0, issued_a}, 32'd0);
            tick();
        end
        check("stall_opa_end", opa_a, 32'h0000_0001);
        ready_a = 1'b1;
        tick();
        check("r2_issued1", {16'd0, issued_a}, 32'd1);
        resp_v_a = 1'b1; resp_r_a = 32'h8000_0000;
        tick();
        check("r2_sig1",    sig_a,             32'h8000_0000);
        check("r2_issued2", {16'd0, issued_a}, 32'd2);
        resp_r_a = 32'd0;
        tick();
        check("r2_sig2", sig_a, 32'h04C1_1DB7);
        tick();
        check("r2_sig3",      sig_a,            32'h0982_3B6E);
        check("r2_drain_busy", {31'd0, busy_a}, 32'd1);
        check("r2_drain_done", {31'd0, done_a}, 32'd0);
        tick();
        check("r2_sig4", sig_a,           32'h1304_76DC);
        check("r2_done", {31'd0, done_a}, 32'd1);
        resp_r_a = 32'h0000_DEAD;
        tick();
        check("done_stray_sig", sig_a, 32'h1304_76DC);
        resp_v_a = 1'b0;

        // ---------------- run 3: async reset mid-DRAIN, then clean rerun
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        check("r3_drain_busy", {31'd0, busy_a}, 32'd1);
        resp_v_a = 1'b1; resp_r_a = 32'h0000_0001;
        tick();
        check("single_resp_sig", sig_a, 32'h0000_0001);
        resp_r_a = 32'h0000_FFFF;
        #2 rst = 1'b1;
        #1;
        check("async_valid",  {31'd0, valid_a},  32'd0);
        check("async_busy",   {31'd0, busy_a},   32'd0);
        check("async_done",   {31'd0, done_a},   32'd0);
        check("async_sig",    sig_a,             32'd0);
        check("async_issued", {16'd0, issued_a}, 32'd0);
        check("async_opa",    opa_a,             32'h0000_0001);
        #1 rst = 1'b0;
        tick();
        check("post_rst_stray_sig", sig_a, 32'd0);
        resp_v_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("r4_opa1", opa_a, 32'h0000_0001);
        tick();
        check("r4_opa2", opa_a, 32'h8020_0003);
        repeat (3) tick();
        resp_v_a = 1'b1; resp_r_a = 32'h0000_0001;
        tick();
        resp_r_a = 32'd0;
        repeat (3) tick();
        resp_v_a = 1'b0;
        check("r4_done", {31'd0, done_a}, 32'd1);
        check("r4_sig",  sig_a,           32'h0000_0008);

        // ---------------- outstanding limit on instance B
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_valid0", {31'd0, valid_b}, 32'd1);
        check("b_opa0",   opa_b,            32'h0000_0001);
        check("b_opb0",   opb_b,            32'h0001_0000);
        check("b_opc0",   opc_b,            32'hFFFF_FFFE);
        check("b_op0",    {28'd0, opc_code_b}, 32'd1);
        tick();
        check("b_valid1", {31'd0, valid_b}, 32'd1);
        tick();
        check("b_limit_valid",  {31'd0, valid_b},  32'd0);
        check("b_limit_issued", {16'd0, issued_b}, 32'd2);
        tick();
        check("b_hold_valid",  {31'd0, valid_b},  32'd0);
        check("b_hold_issued", {16'd0, issued_b}, 32'd2);
        check("b_busy",        {31'd0, busy_b},   32'd1);
        check("b_not_done",    {31'd0, done_b},   32'd0);
        resp_v_b = 1'b1; resp_r_b = 32'h0000_0005;
        tick();
        resp_v_b = 1'b0;
        check("b_restore_valid", {31'd0, valid_b}, 32'd1);
        check("b_sig",           sig_b,            32'h0000_0005);
        tick();
        check("b_issued3",     {16'd0, issued_b}, 32'd3);
        check("b_relimit_vld", {31'd0, valid_b},  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
